// File: rtl/contador_16bits.sv
// 16-bit up/down/step-3/load counter built from four 4-bit slices with per-slice carry/borrow flags.
// Define CONTADOR_SATURATE_EN to clamp at 16'hFFFF/16'h0000 instead of wrapping.
module contador_16bits (
  input  logic        clk,
  input  logic        reset,
  input  logic        enb,
  input  logic [15:0] D,
  input  logic [1:0]  modo,
  output logic [15:0] Q,
  output logic [3:0]  RCO
);

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_DN3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  logic [15:0] q_q, q_d;
  logic [3:0]  rco_q, rco_d;

  logic [3:0]  op_lo;
  logic [3:0]  op_hi;
  logic [4:0]  carry;
  logic [15:0] sum;
  logic [3:0]  wrap;

`ifdef CONTADOR_SATURATE_EN
  function automatic logic [15:0] sat_bound(input logic [1:0] m);
    return (m == MODO_UP) ? 16'hFFFF : 16'h0000;
  endfunction
`endif

  // Subtraction is done as addition of the two's complement: -1 = +FFFF, -3 = +FFFD.
  always_comb begin
    op_lo    = 4'h0;
    op_hi    = 4'h0;
    carry[0] = 1'b1;
    case (modo)
      MODO_DOWN: begin
        op_lo    = 4'hF;
        op_hi    = 4'hF;
        carry[0] = 1'b0;
      end
      MODO_DN3: begin
        op_lo    = 4'hD;
        op_hi    = 4'hF;
        carry[0] = 1'b0;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_slice
    logic [3:0] op_nib;
    assign op_nib = (i == 0) ? op_lo : op_hi;
    assign {carry[i+1], sum[4*i+3:4*i]} =
      {1'b0, q_q[4*i+3:4*i]} + {1'b0, op_nib} + {4'b0000, carry[i]};
    // A borrow out of a slice is the absence of carry in the complemented add.
    assign wrap[i] = (modo == MODO_UP) ? carry[i+1] : ~carry[i+1];
  end

  always_comb begin
    q_d   = q_q;
    rco_d = 4'b0000;
    if (enb) begin
      if (modo == MODO_LOAD) begin
        q_d = D;
      end else begin
        q_d   = sum;
        rco_d = wrap;
`ifdef CONTADOR_SATURATE_EN
        if (wrap[3]) begin
          q_d   = sat_bound(modo);
          rco_d = 4'b1000;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= 16'h0000;
      rco_q <= 4'b0000;
    end else begin
      q_q   <= q_d;
      rco_q <= rco_d;
    end
  end

  assign Q   = q_q;
  assign RCO = rco_q;

endmodule

// File: tb/tb_contador_16bits.sv
// Randomized bench for contador_16bits against an arithmetic reference model.
module tb_contador_16bits;

  logic        clk = 1'b0;
  logic        reset;
  logic        enb;
  logic [15:0] D;
  logic [1:0]  modo;
  logic [15:0] Q;
  logic [3:0]  RCO;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_q;
  logic [3:0]  m_rco;

  contador_16bits dut (
    .clk  (clk),
    .reset(reset),
    .enb  (enb),
    .D    (D),
    .modo (modo),
    .Q    (Q),
    .RCO  (RCO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the count, flags from the low bits below each slice top.
  task automatic model_step(input logic e, input logic [1:0] m, input logic [15:0] d);
    int mask;
    int low;
    int nv;
    m_rco = 4'b0000;
    if (!e) return;
    if (m == 2'b11) begin
      m_q = d;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      mask = (1 << (4*i + 4)) - 1;
      low  = int'(m_q) & mask;
      case (m)
        2'b00:   m_rco[i] = (low == mask);
        2'b01:   m_rco[i] = (low == 0);
        default: m_rco[i] = (low < 3);
      endcase
    end
    case (m)
      2'b00:   nv = int'(m_q) + 1;
      2'b01:   nv = int'(m_q) - 1;
      default: nv = int'(m_q) - 3;
    endcase
`ifdef CONTADOR_SATURATE_EN
    if (nv < 0 || nv > 65535) begin
      nv    = (m == 2'b00) ? 65535 : 0;
      m_rco = 4'b1000;
    end
`endif
    m_q = nv[15:0];
  endtask

  task automatic cyc(input string tag, input logic e, input logic [1:0] m, input logic [15:0] d);
    enb  = e;
    modo = m;
    D    = d;
    @(posedge clk);
    model_step(e, m, d);
    #1;
    check({tag, "_Q"}, {16'h0, Q}, {16'h0, m_q});
    check({tag, "_RCO"}, {28'h0, RCO}, {28'h0, m_rco});
    // Change D mid-cycle; it must not matter since D is sampled only at edges.
    D = 16'($urandom);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    m_q   = 16'h0000;
    m_rco = 4'b0000;
    check({tag, "_Q"}, {16'h0, Q}, 32'h0);
    check({tag, "_RCO"}, {28'h0, RCO}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [15:0] corners [8] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF,
                               16'hFFFE, 16'h0FFF, 16'h00FF, 16'h1000};

  initial begin
    reset = 1'b0;
    enb   = 1'b0;
    modo  = 2'b00;
    D     = 16'h0000;
    m_q   = 16'h0000;
    m_rco = 4'b0000;
    #1;
    async_reset("por");

    cyc("ld1234", 1'b1, 2'b11, 16'h1234);
    cyc("up_a", 1'b1, 2'b00, 16'h0000);
    async_reset("midrst");
    cyc("rel1", 1'b1, 2'b00, 16'h0);
    cyc("rel2", 1'b1, 2'b00, 16'h0);
    cyc("rel3", 1'b1, 2'b00, 16'h0);
    check("rel_q3", {16'h0, Q}, 32'h0003);

    cyc("ld00FE", 1'b1, 2'b11, 16'h00FE);
    cyc("fe_up1", 1'b1, 2'b00, 16'h0);
    check("fe_rco1", {28'h0, RCO}, 32'h0);
    cyc("fe_up2", 1'b1, 2'b00, 16'h0);
    check("fe_q2", {16'h0, Q}, 32'h0100);
    check("fe_rco2", {28'h0, RCO}, 32'h3);
    cyc("fe_up3", 1'b1, 2'b00, 16'h0);
    check("fe_q3", {16'h0, Q}, 32'h0101);

    cyc("ldFFFF", 1'b1, 2'b11, 16'hFFFF);
    cyc("ffff_up", 1'b1, 2'b00, 16'h0);
`ifdef CONTADOR_SATURATE_EN
    check("ffff_q", {16'h0, Q}, 32'hFFFF);
    check("ffff_rco", {28'h0, RCO}, 32'h8);
`else
    check("ffff_q", {16'h0, Q}, 32'h0000);
    check("ffff_rco", {28'h0, RCO}, 32'hF);
`endif

    cyc("ld0001", 1'b1, 2'b11, 16'h0001);
    cyc("one_dn3", 1'b1, 2'b10, 16'h0);
`ifdef CONTADOR_SATURATE_EN
    check("dn3_q", {16'h0, Q}, 32'h0000);
    check("dn3_rco", {28'h0, RCO}, 32'h8);
`else
    check("dn3_q", {16'h0, Q}, 32'hFFFE);
    check("dn3_rco", {28'h0, RCO}, 32'hF);
`endif

    cyc("ld0010", 1'b1, 2'b11, 16'h0010);
    cyc("dn_a", 1'b1, 2'b01, 16'h0);
    check("dn_a_q", {16'h0, Q}, 32'h000F);
    check("dn_a_rco", {28'h0, RCO}, 32'h1);
    cyc("dn_b", 1'b1, 2'b01, 16'h0);
    check("dn_b_q", {16'h0, Q}, 32'h000E);

    cyc("ld0ABC", 1'b1, 2'b11, 16'h0ABC);
    cyc("pre_hold", 1'b1, 2'b00, 16'h0);
    cyc("ld0ABC2", 1'b1, 2'b11, 16'h0ABC);
    for (int i = 0; i < 4; i++) cyc("hold", 1'b0, 2'b00, 16'($urandom));
    check("hold_q", {16'h0, Q}, 32'h0ABC);
    check("hold_rco", {28'h0, RCO}, 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic [1:0]  m;
      logic        e;
      logic [15:0] d;
      e = ($urandom_range(0, 7) != 0);
      m = 2'($urandom);
      d = ($urandom_range(0, 1) != 0) ? corners[$urandom_range(0, 7)] : 16'($urandom);
      if (m == 2'b11 && $urandom_range(0, 3) != 0) m = 2'($urandom_range(0, 2));
      cyc("rnd", e, m, d);
      if ($urandom_range(0, 79) == 0) async_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
